// File: rtl/lut_eval_pkg.sv
// ============================================================================
// Module      : lut_eval_pkg
// Description : Shared types and constants for the lut_eval truth-table block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lut_eval_pkg;

    localparam int N_IN_MAX = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        SWEEP = 2'd3
    } state_t;

    function automatic int rows(input int n);
        return 1 << n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lut_eval_if.sv
// ============================================================================
// Module      : lut_eval_if
// Description : Load/evaluate/sweep signal bundle for lut_eval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lut_eval_if #(
    parameter int N_IN = 3
);

    logic            cfg_start;
    logic            cfg_valid;
    logic            cfg_bit;
    logic            cfg_ready;
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            out;
    logic            out_valid;
    logic            loaded;
    logic            sweep_start;
    logic [N_IN-1:0] sweep_idx;

    modport master (
        output cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, sweep_start,
        input  cfg_ready, out, out_valid, loaded, sweep_idx
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit, in_valid, in_vec, sweep_start,
        output cfg_ready, out, out_valid, loaded, sweep_idx
    );

endinterface

`default_nettype wire

// File: rtl/lut_eval_table.sv
// ============================================================================
// Module      : lut_eval_table
// Description : ROWS-bit truth-table storage with serial write counter and
//               combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_eval_table
    import lut_eval_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            clr,
    input  wire logic            wr_en,
    input  wire logic            wr_bit,
    input  wire logic [N_IN-1:0] rd_addr,
    output logic                 rd_data,
    output logic                 last_row
);

    localparam int              c_rows     = rows(N_IN);
    localparam logic [N_IN-1:0] c_last_row = N_IN'(c_rows - 1);

    logic [c_rows-1:0] r_mem;
    logic [N_IN-1:0]   r_cnt;

    // A restart only rewinds the counter; untouched rows keep old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (wr_en) begin
            r_mem[r_cnt] <= wr_bit;
            r_cnt        <= r_cnt + 1'b1;
        end
    end

    assign rd_data  = r_mem[rd_addr];
    assign last_row = wr_en && (r_cnt == c_last_row);

endmodule

`default_nettype wire

// File: rtl/lut_eval.sv
// ============================================================================
// Module      : lut_eval
// Description : Runtime-programmable N_IN-input truth-table evaluator with
//               serial load and optional full-table sweep (LUT_EVAL_SWEEP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_eval
    import lut_eval_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    lut_eval_if.slave   bus
);

    localparam int              c_rows     = rows(N_IN);
    localparam logic [N_IN-1:0] c_last_row = N_IN'(c_rows - 1);

    if (N_IN < 1 || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("lut_eval: N_IN out of range 1..6");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_out;
    logic            w_out_nxt;
    logic            r_out_valid;
    logic            w_out_valid_nxt;
    logic            r_loaded;
    logic            w_loaded_nxt;

    logic            w_wr_en;
    logic            w_last_row;
    logic [N_IN-1:0] w_rd_addr;
    logic            w_rd_data;

`ifdef LUT_EVAL_SWEEP_EN
    logic [N_IN-1:0] r_sweep_idx;
    logic [N_IN-1:0] w_sweep_idx_nxt;
    logic            w_sweep_go;

    assign w_sweep_go = (r_state == RUN) && r_loaded && bus.sweep_start;
`else
    logic w_unused_sweep_start;

    assign w_unused_sweep_start = bus.sweep_start;
`endif

    // A new cfg_start wins over any in-flight write in the same cycle.
    assign w_wr_en = (r_state == LOAD) && bus.cfg_valid && !bus.cfg_start;

    lut_eval_table #(
        .N_IN (N_IN)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.cfg_start),
        .wr_en    (w_wr_en),
        .wr_bit   (bus.cfg_bit),
        .rd_addr  (w_rd_addr),
        .rd_data  (w_rd_data),
        .last_row (w_last_row)
    );

    // Read address kept apart from the FSM so rd_data has no path back into it.
    always_comb begin
        w_rd_addr = bus.in_vec;
`ifdef LUT_EVAL_SWEEP_EN
        if (r_state == SWEEP) begin
            w_rd_addr = r_sweep_idx + 1'b1;
        end else if (bus.sweep_start) begin
            w_rd_addr = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_loaded    <= 1'b0;
`ifdef LUT_EVAL_SWEEP_EN
            r_sweep_idx <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_loaded    <= w_loaded_nxt;
`ifdef LUT_EVAL_SWEEP_EN
            r_sweep_idx <= w_sweep_idx_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_loaded_nxt    = r_loaded;
`ifdef LUT_EVAL_SWEEP_EN
        w_sweep_idx_nxt = r_sweep_idx;
`endif

        if (bus.cfg_start) begin
            w_state_nxt  = LOAD;
            w_loaded_nxt = 1'b0;
`ifdef LUT_EVAL_SWEEP_EN
            w_sweep_idx_nxt = '0;
`endif
        end else begin
            case (r_state)
                EMPTY: begin
                end
                LOAD: begin
                    if (w_last_row) begin
                        w_state_nxt  = RUN;
                        w_loaded_nxt = 1'b1;
                    end
                end
                RUN: begin
`ifdef LUT_EVAL_SWEEP_EN
                    if (w_sweep_go) begin
                        w_state_nxt     = SWEEP;
                        w_out_nxt       = w_rd_data;
                        w_out_valid_nxt = 1'b1;
                        w_sweep_idx_nxt = '0;
                    end else
`endif
                    if (bus.in_valid) begin
                        w_out_nxt       = w_rd_data;
                        w_out_valid_nxt = 1'b1;
                    end
                end
`ifdef LUT_EVAL_SWEEP_EN
                SWEEP: begin
                    if (r_sweep_idx == c_last_row) begin
                        w_state_nxt     = RUN;
                        w_sweep_idx_nxt = '0;
                    end else begin
                        w_out_nxt       = w_rd_data;
                        w_out_valid_nxt = 1'b1;
                        w_sweep_idx_nxt = r_sweep_idx + 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    assign bus.cfg_ready = (r_state == LOAD);
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.loaded    = r_loaded;
`ifdef LUT_EVAL_SWEEP_EN
    assign bus.sweep_idx = r_sweep_idx;
`else
    assign bus.sweep_idx = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_eval.sv
// ============================================================================
// Module      : tb_lut_eval
// Description : Self-checking bench for lut_eval: directed table loads and
//               evaluations plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_eval;

    localparam int N_IN = 3;
    localparam int ROWS = 1 << N_IN;
`ifdef LUT_EVAL_SWEEP_EN
    localparam bit SWEEP_ON = 1'b1;
`else
    localparam bit SWEEP_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lut_eval_if #(.N_IN(N_IN)) bus ();

    lut_eval #(.N_IN(N_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=empty 1=loading 2=running 3=sweeping.
    int m_mode   = 0;
    bit m_tab[ROWS];
    int m_cnt    = 0;
    bit m_loaded = 1'b0;
    bit m_out    = 1'b0;
    bit m_ov     = 1'b0;
    int m_idx    = 0;
    bit m_armed  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0;
            foreach (m_tab[i]) m_tab[i] = 1'b0;
            m_cnt    = 0;
            m_loaded = 1'b0;
            m_out    = 1'b0;
            m_ov     = 1'b0;
            m_idx    = 0;
            m_armed  = 1'b1;
        end else if (m_armed) begin
            m_ov = 1'b0;
            if (bus.cfg_start) begin
                m_mode   = 1;
                m_cnt    = 0;
                m_loaded = 1'b0;
                m_idx    = 0;
            end else if (m_mode == 1) begin
                if (bus.cfg_valid) begin
                    m_tab[m_cnt] = bus.cfg_bit;
                    m_cnt++;
                    if (m_cnt == ROWS) begin
                        m_mode   = 2;
                        m_loaded = 1'b1;
                        m_cnt    = 0;
                    end
                end
            end else if (m_mode == 2) begin
                if (SWEEP_ON && bus.sweep_start) begin
                    m_mode = 3;
                    m_idx  = 0;
                    m_out  = m_tab[0];
                    m_ov   = 1'b1;
                end else if (bus.in_valid) begin
                    m_out = m_tab[int'(bus.in_vec)];
                    m_ov  = 1'b1;
                end
            end else if (m_mode == 3) begin
                if (m_idx == ROWS - 1) begin
                    m_mode = 2;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                    m_out = m_tab[m_idx];
                    m_ov  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_armed) begin
            check("model_out_valid", int'(bus.out_valid), int'(m_ov));
            check("model_out", int'(bus.out), int'(m_out));
            check("model_loaded", int'(bus.loaded), int'(m_loaded));
            check("model_cfg_ready", int'(bus.cfg_ready), int'(m_mode == 1));
            check("model_sweep_idx", int'(bus.sweep_idx), m_idx);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.cfg_start   = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_bit     = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_vec      = '0;
        bus.sweep_start = 1'b0;
    endtask

    task automatic load_table(input logic [63:0] bits, input bit stalls);
        int r;
        idle();
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        r = 0;
        while (r < ROWS) begin
            if (stalls && $urandom_range(0, 3) == 0) begin
                bus.cfg_valid = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_vec    = N_IN'($urandom);
                step();
                check("load_stall_no_eval", int'(bus.out_valid), 0);
            end else begin
                bus.cfg_valid = 1'b1;
                bus.cfg_bit   = bits[r];
                bus.in_valid  = 1'b0;
                step();
                r++;
                if (r < ROWS) check("loaded_mid_load", int'(bus.loaded), 0);
            end
        end
        idle();
        check("loaded_after_last", int'(bus.loaded), 1);
        check("cfg_ready_after_last", int'(bus.cfg_ready), 0);
    endtask

    task automatic eval_chk(input int v, input int exp);
        bus.in_valid = 1'b1;
        bus.in_vec   = N_IN'(v);
        step();
        check("eval_out_valid", int'(bus.out_valid), 1);
        check("eval_out", int'(bus.out), exp);
    endtask

    initial begin
        logic [7:0] c96;
        c96 = 8'h96;
        idle();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Fresh block ignores evaluation requests.
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'b101;
        step();
        idle();
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out", int'(bus.out), 0);
        check("reset_loaded", int'(bus.loaded), 0);
        check("reset_cfg_ready", int'(bus.cfg_ready), 0);

        // All-ones table, back-to-back evaluation of every vector.
        load_table(64'hFF, 1'b0);
        for (int v = 0; v < ROWS; v++) eval_chk(v, 1);
        idle();
        step();
        check("idle_out_valid", int'(bus.out_valid), 0);
        check("idle_out_hold", int'(bus.out), 1);

        // Parity-like 0x96 table.
        load_table(64'h96, 1'b1);
        eval_chk(3, 0);
        eval_chk(7, 1);
        for (int v = 0; v < ROWS; v++) eval_chk(v, int'(c96[v]));
        idle();

        // Restart mid-load, then reload 0x01.
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_bit   = 1'b1;
            step();
        end
        bus.cfg_valid = 1'b0;
        check("partial_loaded", int'(bus.loaded), 0);
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'b000;
        step();
        check("partial_eval_ignored", int'(bus.out_valid), 0);
        load_table(64'h01, 1'b1);
        for (int v = 0; v < ROWS; v++) eval_chk(v, (v == 0) ? 1 : 0);
        idle();

        load_table(64'h96, 1'b0);
`ifdef LUT_EVAL_SWEEP_EN
        // Sweep beats a simultaneous evaluation of row 7.
        bus.sweep_start = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_vec      = 3'b111;
        step();
        bus.sweep_start = 1'b0;
        check("sweep_row0_valid", int'(bus.out_valid), 1);
        check("sweep_row0_out", int'(bus.out), 0);
        check("sweep_row0_idx", int'(bus.sweep_idx), 0);
        for (int i = 1; i < ROWS; i++) begin
            bus.in_vec = N_IN'($urandom);
            step();
            check("sweep_valid", int'(bus.out_valid), 1);
            check("sweep_out", int'(bus.out), int'(c96[i]));
            check("sweep_idx", int'(bus.sweep_idx), i);
        end
        bus.in_valid = 1'b0;
        step();
        check("sweep_end_valid", int'(bus.out_valid), 0);
        check("sweep_end_idx", int'(bus.sweep_idx), 0);
        eval_chk(7, 1);
        idle();

        // Reset while row 3 is on the output.
        bus.sweep_start = 1'b1;
        step();
        bus.sweep_start = 1'b0;
        repeat (3) step();
        check("sweep_at_row3", int'(bus.sweep_idx), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_sweep_valid", int'(bus.out_valid), 0);
        check("rst_sweep_loaded", int'(bus.loaded), 0);
        check("rst_sweep_idx", int'(bus.sweep_idx), 0);
        check("rst_sweep_ready", int'(bus.cfg_ready), 0);
`else
        // Without the sweep feature, sweep_start does nothing.
        bus.sweep_start = 1'b1;
        step();
        check("nosweep_valid", int'(bus.out_valid), 0);
        check("nosweep_idx", int'(bus.sweep_idx), 0);
        bus.in_valid = 1'b1;
        bus.in_vec   = 3'b111;
        step();
        check("nosweep_eval_valid", int'(bus.out_valid), 1);
        check("nosweep_eval_out", int'(bus.out), 1);
        idle();

        // Reset mid-load.
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        check("rst_load_ready", int'(bus.cfg_ready), 0);
        check("rst_load_loaded", int'(bus.loaded), 0);
        check("rst_load_valid", int'(bus.out_valid), 0);
`endif
        idle();

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 800; c++) begin
            bus.cfg_start   = ($urandom_range(0, 39) == 0);
            bus.cfg_valid   = ($urandom_range(0, 9) < 7);
            bus.cfg_bit     = 1'($urandom);
            bus.in_valid    = ($urandom_range(0, 9) < 6);
            bus.in_vec      = N_IN'($urandom);
            bus.sweep_start = ($urandom_range(0, 29) == 0);
            rst_n           = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_eval.md
# lut_eval

Parametrised, runtime-programmable truth-table evaluator. It replaces the fixed per-function N-input truth-table modules (one module per hex code, e.g. 0xFF for 3 inputs) with a single block. The 2^N_IN-row table is loaded serially over a valid/ready handshake and then evaluated with one-cycle registered latency. It sits between the circuit-assignment stimulus driver and the logic-comparison scoreboard, and one instance covers every N-input function code.

## Interface
- N_IN, 3, number of inputs; legal range 1..6; ROWS = 2^N_IN.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_start  in  1  pulse; begins (or restarts) a table load.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  next table row value; row 0 first.
- cfg_ready  out  1  block accepts cfg_bit this cycle.
- in_valid  in  1  in_vec is valid for evaluation.
- in_vec  in  N_IN  input combination; bit N_IN-1 = in1 (MSB), bit 0 = last input.
- out  out  1  registered table[in_vec] or sweep row value.
- out_valid  out  1  out is valid this cycle.
- loaded  out  1  a complete table is held.
- sweep_start  in  1  pulse; emits the whole table (see Configuration).
- sweep_idx  out  N_IN  row index of the current sweep output.

## Operation
- States: EMPTY (no table), LOAD, RUN, SWEEP.
- Reset values: state=EMPTY, table=all 0, out=0, out_valid=0, cfg_ready=0, loaded=0, sweep_idx=0, row counter=0.
- cfg_start in any state (including LOAD and SWEEP):
  - Enter LOAD.
  - Clear the row counter and set loaded=0.
  - Abort any sweep and drop any pending evaluation.
- LOAD:
  - cfg_ready=1.
  - Each cycle with cfg_valid&&cfg_ready writes table[cnt]=cfg_bit, then cnt++.
  - On acceptance of row ROWS-1: go to RUN and set loaded=1 on the next cycle. cfg_ready drops that same next cycle.
  - Rows not yet rewritten keep their old value, but loaded stays 0 until the load completes.
- RUN: in_valid causes out=table[in_vec] and out_valid=1 on the next cycle. Back-to-back in_valid gives back-to-back results.
- In EMPTY and LOAD, in_valid is ignored and out_valid=0.
- out holds its last value while out_valid=0.
- Simultaneous events:
  - cfg_start beats sweep_start, which beats in_valid. The losing request is discarded, not queued.
  - cfg_valid outside LOAD is ignored.

## Timing
- Eval latency: 1 cycle from in_valid to out_valid. Throughput is 1 per cycle.
- Load time: ROWS accepted handshakes. loaded rises 1 cycle after the last accepted bit.
- Sweep: out_valid=1 for exactly ROWS consecutive cycles, starting 1 cycle after sweep_start.
- Reset asserted mid-load or mid-sweep returns the block to the reset values on the next edge. The table is cleared.

## Configuration
- LUT_EVAL_SWEEP_EN defined:
  - sweep_start in RUN with loaded=1 enters SWEEP.
  - For i=0..ROWS-1 on consecutive cycles: out=table[i], sweep_idx=i, out_valid=1.
  - After row ROWS-1, return to RUN with sweep_idx=0.
  - in_valid is ignored during SWEEP.
  - sweep_start outside RUN is ignored.
- LUT_EVAL_SWEEP_EN undefined: SWEEP state and its counter are not built. sweep_start is ignored and sweep_idx is tied to 0. The ports stay present so instantiations do not change.

## Structure
- Package lut_eval_pkg:
  - state enum {EMPTY, LOAD, RUN, SWEEP}.
  - function rows(n) returning 2^n.
  - N_IN_MAX=6 constant.
- One sub-module, lut_eval_table:
  - ROWS-bit storage, write counter, and combinational read port.
  - Exposes last_row when cnt==ROWS-1 and a write occurs.
- The top level holds the FSM, output registers, and the sweep counter.

## Test plan
- Reset then in_valid with in_vec=3'b101 -> out_valid stays 0, out=0, loaded=0.
- N_IN=3, load bits 11111111 (row 0 first), then evaluate all 8 vectors -> out=1 every time with 1-cycle latency, loaded=1 one cycle after the 8th bit.
- Load 0x96 (bits row0..7 = 0,1,1,0,1,0,0,1), then 3'b011 -> out=0; 3'b111 -> out=1; back-to-back stream gives out_valid high every cycle.
- cfg_start after 4 bits, reload 0x01 -> loaded stays 0 until the 8 new bits are accepted; then only in_vec=0 gives out=1.
- With LUT_EVAL_SWEEP_EN, table 0x96, pulse sweep_start with in_valid and sweep_start together:
  - sweep wins.
  - 8 cycles of out=0,1,1,0,1,0,0,1 with sweep_idx=0..7.
  - Return to RUN.
- rst_n low mid-sweep at row 3 -> next cycle out_valid=0, loaded=0, table is zero, state=EMPTY.
